pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central stall/flush controller for the 5-stage pipeline. Collects stall requests from IF, ID, EX and MEM and drives the shared 6-bit `stall` vector consumed by the PC register and every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB). Sequences precise exception entry: it accepts an exception from MEM, issues a one-cycle pipeline flush and redirects the PC. Optional performance counters track stall and flush activity.

## Interface
Parameters:
- `RESET_PC`, 32'hBFC0_0000, reserved; not used by the datapath here, kept for the top-level parameter list.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_stallreq_if`  in  1  IF stall request (instruction fetch not ready).
- `i_stallreq_id`  in  1  ID stall request (load-use hazard).
- `i_stallreq_ex`  in  1  EX stall request (multi-cycle mult/div busy).
- `i_stallreq_mem`  in  1  MEM stall request (data access not ready).
- `i_excp_valid`  in  1  MEM stage reports an exception; held until accepted.
- `i_excp_vector`  in  32  handler address for the exception.
- `o_stall`  out  6  bit k=1 stops stage k: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB.
- `o_flush`  out  1  clears every pipeline register this cycle.
- `o_pc_redirect`  out  1  PC loads `o_new_pc` this cycle.
- `o_new_pc`  out  32  redirect target.
- `o_excp_ack`  out  1  one-cycle acceptance pulse to MEM.
- `o_busy`  out  1  high while not in RUN.
- `o_perf_stall_cycles`  out  32  cycles with `o_stall` != 0.
- `o_perf_flushes`  out  16  flushes issued.

## Operation
- States: RUN, FLUSH. Reset -> RUN.
- RUN, stall vector (combinational, same cycle as requests, highest priority wins):
  - mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; if -> 6'b000011; none -> 6'b000000.
  - A downstream register whose stage is stalled while the next stage is not inserts a bubble; this is the pipeline registers' responsibility.
- Exception acceptance in RUN: `i_excp_valid`=1 and `i_stallreq_mem`=0. In that cycle:
  - `o_excp_ack`=1.
  - `i_excp_vector` is latched.
  - Next state is FLUSH.
  - `o_stall` follows the normal priority rule.
  - MEM kills the write of the excepting instruction itself.
- `i_excp_valid` with `i_stallreq_mem`=1: not accepted, no ack; MEM keeps it asserted.
- FLUSH lasts exactly one cycle:
  - `o_flush`=1, `o_pc_redirect`=1, `o_new_pc`=latched vector, `o_stall`=6'b000000.
  - All stall requests and `i_excp_valid` are ignored.
  - Next state is RUN.
- `o_busy` = (state == FLUSH).
- `o_new_pc` holds the last latched vector at all times; 0 after reset.

## Timing
- Reset values:
  - state RUN, latched vector 0.
  - `o_flush`, `o_pc_redirect`, `o_excp_ack`, `o_busy` = 0.
  - `o_new_pc` = 0, both perf counters = 0.
  - `o_stall` = combinational function of requests (6'b000000 with no requests).
- Reset asserted during FLUSH aborts it: no flush/redirect in the following cycle.
- Latency: exception accepted in cycle N -> flush+redirect in cycle N+1 -> normal stall decode from cycle N+2.
- A new exception can be accepted at the earliest in cycle N+2.
- Stall decode has zero latency; `o_stall` is never registered.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `o_perf_stall_cycles` increments by 1 every cycle `o_stall` != 0, wrapping at 2^32.
  - `o_perf_flushes` increments once per FLUSH cycle, wrapping at 2^16.
  - Both counters clear on reset.
- Not defined: both counters tied to 0 and no counter flops are generated.

## Test plan
- Priority: assert `i_stallreq_if` and `i_stallreq_ex` together -> `o_stall`=6'b001111. Add `i_stallreq_mem` -> 6'b011111. Drop all -> 6'b000000 the same cycle.
- Exception entry: `i_excp_valid`=1, vector 32'hBFC0_0380, no MEM stall in cycle N -> cycle N has `o_excp_ack`=1. Cycle N+1 has `o_flush`=1, `o_pc_redirect`=1, `o_new_pc`=32'hBFC0_0380, `o_stall`=0.
- Exception blocked by MEM stall: `i_excp_valid`=1 with `i_stallreq_mem`=1 for 3 cycles -> no ack, `o_stall`=6'b011111. Ack lands in the first cycle the MEM stall drops.
- Requests during FLUSH: `i_stallreq_id`=1 and a new `i_excp_valid` in the FLUSH cycle -> `o_stall`=0 and no ack in that cycle. Next cycle `o_stall`=6'b000111 and the exception is acked.
- Reset mid-operation: assert `reset` in the acceptance cycle -> next cycle `o_flush`=0, `o_pc_redirect`=0, `o_new_pc`=0, `o_busy`=0.
- Perf (with `PIPE_CTRL_PERF_EN`): 5 stall cycles and 2 exceptions -> `o_perf_stall_cycles`=5, `o_perf_flushes`=2. Without the macro, both read 0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Stall/flush controller handshake bundle: pipeline side is the master,
// the controller is the slave.
interface pipeline_ctrl_if;
  logic        i_stallreq_if;
  logic        i_stallreq_id;
  logic        i_stallreq_ex;
  logic        i_stallreq_mem;
  logic        i_excp_valid;
  logic [31:0] i_excp_vector;
  logic [5:0]  o_stall;
  logic        o_flush;
  logic        o_pc_redirect;
  logic [31:0] o_new_pc;
  logic        o_excp_ack;
  logic        o_busy;
  logic [31:0] o_perf_stall_cycles;
  logic [15:0] o_perf_flushes;

  modport master (
    output i_stallreq_if, i_stallreq_id, i_stallreq_ex, i_stallreq_mem,
           i_excp_valid, i_excp_vector,
    input  o_stall, o_flush, o_pc_redirect, o_new_pc, o_excp_ack, o_busy,
           o_perf_stall_cycles, o_perf_flushes
  );

  modport slave (
    input  i_stallreq_if, i_stallreq_id, i_stallreq_ex, i_stallreq_mem,
           i_excp_valid, i_excp_vector,
    output o_stall, o_flush, o_pc_redirect, o_new_pc, o_excp_ack, o_busy,
           o_perf_stall_cycles, o_perf_flushes
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: priority stall decode plus one-cycle
// exception flush/redirect. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic          clk,
  input  logic          reset,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e      state_q;
  logic [31:0] vec_q;
  logic        flush_q;
  logic        accept;
  logic [5:0]  stall_dec;

  // Kept only for the top-level parameter list.
  logic unused_reset_pc;
  assign unused_reset_pc = ^RESET_PC;

  always_comb begin
    stall_dec = 6'b000000;
    if (bus.i_stallreq_mem)     stall_dec = 6'b011111;
    else if (bus.i_stallreq_ex) stall_dec = 6'b001111;
    else if (bus.i_stallreq_id) stall_dec = 6'b000111;
    else if (bus.i_stallreq_if) stall_dec = 6'b000011;
  end

  // An exception waits while MEM itself is stalled.
  assign accept = (state_q == RUN) && bus.i_excp_valid && !bus.i_stallreq_mem && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      vec_q   <= 32'h0;
      flush_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: if (accept) begin
          state_q <= FLUSH;
          vec_q   <= bus.i_excp_vector;
          flush_q <= 1'b1;
        end
        FLUSH: begin
          state_q <= RUN;
          flush_q <= 1'b0;
        end
        default: begin
          state_q <= RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_stall       = (state_q == RUN) ? stall_dec : 6'b000000;
  assign bus.o_flush       = flush_q;
  assign bus.o_pc_redirect = flush_q;
  assign bus.o_busy        = flush_q;
  assign bus.o_new_pc      = vec_q;
  assign bus.o_excp_ack    = accept;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  assign stall_cnt_d = stall_cnt_q + {31'h0, (bus.o_stall != 6'b000000)};
  assign flush_cnt_d = flush_cnt_q + {15'h0, flush_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 16'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.o_perf_stall_cycles = stall_cnt_q;
  assign bus.o_perf_flushes      = flush_cnt_q;
`else
  assign bus.o_perf_stall_cycles = 32'h0;
  assign bus.o_perf_flushes      = 16'h0;
`endif

endmodule
